// File: rtl/fft_output_serial.sv
// FFT output serializer: captures a quad of complex samples and streams them one per
// cycle with bin index and end-of-frame flag.
module fft_output_serial #(
    parameter int unsigned BIT      = 17,
    parameter int unsigned ADDR_BIT = 8
) (
    input  logic                iCLK,
    input  logic                iRESET,
    input  logic                iCLR,
    input  logic                iVALID,
    output logic                oREADY,
    input  logic [BIT-1:0]      iX0_RE,
    input  logic [BIT-1:0]      iX0_IM,
    input  logic [BIT-1:0]      iX1_RE,
    input  logic [BIT-1:0]      iX1_IM,
    input  logic [BIT-1:0]      iX2_RE,
    input  logic [BIT-1:0]      iX2_IM,
    input  logic [BIT-1:0]      iX3_RE,
    input  logic [BIT-1:0]      iX3_IM,
    output logic                oVALID,
    input  logic                iREADY,
    output logic [BIT-1:0]      oRE,
    output logic [BIT-1:0]      oIM,
    output logic [ADDR_BIT-1:0] oINDEX,
    output logic                oLAST
);

    localparam logic [ADDR_BIT-1:0] LastIndex = {ADDR_BIT{1'b1}};

    logic [BIT-1:0]      bufRe [4];
    logic [BIT-1:0]      bufIm [4];
    logic                fullQ, fullD;
    logic [1:0]          laneQ, laneD;
    logic [ADDR_BIT-1:0] indexQ, indexD;
    logic                accept, transfer;

    // iREADY feeds oREADY combinationally so a new quad can land as lane 3 leaves.
    assign oREADY   = iRESET && !iCLR && (!fullQ || (laneQ == 2'd3 && iREADY));
    assign accept   = iVALID && oREADY;
    assign transfer = fullQ && iREADY;

    assign oVALID = fullQ;
    assign oRE    = bufRe[laneQ];
    assign oIM    = bufIm[laneQ];
    assign oINDEX = indexQ;
    assign oLAST  = fullQ && (indexQ == LastIndex);

    always_comb begin
        fullD  = fullQ;
        laneD  = laneQ;
        indexD = indexQ;
        if (iCLR) begin
            fullD  = 1'b0;
            laneD  = 2'd0;
            indexD = '0;
        end else begin
            if (transfer) begin
                indexD = indexQ + 1'b1;
                if (laneQ != 2'd3) begin
                    laneD = laneQ + 2'd1;
                end else begin
                    fullD = 1'b0;
                end
            end
            if (accept) begin
                fullD = 1'b1;
                laneD = 2'd0;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            fullQ  <= 1'b0;
            laneQ  <= 2'd0;
            indexQ <= '0;
        end else begin
            fullQ  <= fullD;
            laneQ  <= laneD;
            indexQ <= indexD;
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            for (int i = 0; i < 4; i++) begin
                bufRe[i] <= '0;
                bufIm[i] <= '0;
            end
        end else if (accept) begin
            bufRe[0] <= iX0_RE;
            bufIm[0] <= iX0_IM;
            bufRe[1] <= iX1_RE;
            bufIm[1] <= iX1_IM;
            bufRe[2] <= iX2_RE;
            bufIm[2] <= iX2_IM;
            bufRe[3] <= iX3_RE;
            bufIm[3] <= iX3_IM;
        end
    end

endmodule

// File: tb/tb_fft_output_serial.sv
// Scoreboard bench for fft_output_serial with an 8-sample frame.
module tb_fft_output_serial;

    localparam int unsigned BIT      = 17;
    localparam int unsigned ADDR_BIT = 3;

    logic                iCLK = 1'b0;
    logic                iRESET, iCLR, iVALID, iREADY;
    logic                oREADY, oVALID, oLAST;
    logic [BIT-1:0]      iX0_RE, iX0_IM, iX1_RE, iX1_IM, iX2_RE, iX2_IM, iX3_RE, iX3_IM;
    logic [BIT-1:0]      oRE, oIM;
    logic [ADDR_BIT-1:0] oINDEX;

    typedef struct {
        logic [BIT-1:0]      re;
        logic [BIT-1:0]      im;
        logic [ADDR_BIT-1:0] idx;
        logic                last;
    } sampleT;

    sampleT              expQ[$];
    logic [ADDR_BIT-1:0] expIdx;
    logic [BIT-1:0]      quadRe [4];
    logic [BIT-1:0]      quadIm [4];
    logic                pending;
    int                  checks = 0;
    int                  failures = 0;

    fft_output_serial #(.BIT(BIT), .ADDR_BIT(ADDR_BIT)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iCLR(iCLR), .iVALID(iVALID), .oREADY(oREADY),
        .iX0_RE(iX0_RE), .iX0_IM(iX0_IM), .iX1_RE(iX1_RE), .iX1_IM(iX1_IM),
        .iX2_RE(iX2_RE), .iX2_IM(iX2_IM), .iX3_RE(iX3_RE), .iX3_IM(iX3_IM),
        .oVALID(oVALID), .iREADY(iREADY), .oRE(oRE), .oIM(oIM), .oINDEX(oINDEX),
        .oLAST(oLAST)
    );

    always #5 iCLK = ~iCLK;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic loadQuad(input bit extremes);
        for (int i = 0; i < 4; i++) begin
            if (extremes) begin
                quadRe[i] = i[0] ? 17'h0FFFF : 17'h10000;
                quadIm[i] = i[0] ? 17'h10000 : 17'h0FFFF;
            end else begin
                quadRe[i] = BIT'($urandom);
                quadIm[i] = BIT'($urandom);
            end
        end
        pending = 1'b1;
    endtask

    // One clock: score at the falling edge, then leave the bench just after the rising edge.
    task automatic step();
        logic expReady;
        sampleT s;
        iVALID = pending;
        {iX0_RE, iX1_RE, iX2_RE, iX3_RE} = {quadRe[0], quadRe[1], quadRe[2], quadRe[3]};
        {iX0_IM, iX1_IM, iX2_IM, iX3_IM} = {quadIm[0], quadIm[1], quadIm[2], quadIm[3]};
        @(negedge iCLK);
        expReady = iRESET && !iCLR && (expQ.size() == 0 || (expQ.size() == 1 && iREADY));
        checkVal("oREADY", 32'(oREADY), 32'(expReady));
        checkVal("oVALID", 32'(oVALID), 32'(expQ.size() != 0));
        if (expQ.size() != 0) begin
            checkVal("oRE", 32'(oRE), 32'(expQ[0].re));
            checkVal("oIM", 32'(oIM), 32'(expQ[0].im));
            checkVal("oINDEX", 32'(oINDEX), 32'(expQ[0].idx));
            checkVal("oLAST", 32'(oLAST), 32'(expQ[0].last));
        end else begin
            checkVal("oLAST_idle", 32'(oLAST), 32'd0);
        end
        if (!iRESET || iCLR) begin
            expQ.delete();
            expIdx = '0;
        end else begin
            if (expQ.size() != 0 && iREADY) void'(expQ.pop_front());
            if (iVALID && expReady) begin
                for (int i = 0; i < 4; i++) begin
                    s.re   = quadRe[i];
                    s.im   = quadIm[i];
                    s.idx  = expIdx;
                    s.last = (expIdx == {ADDR_BIT{1'b1}});
                    expQ.push_back(s);
                    expIdx = expIdx + 1'b1;
                end
                pending = 1'b0;
            end
        end
        @(posedge iCLK);
        #1;
    endtask

    // Stream with iREADY=1, offering up to nQuads quads as soon as the previous is taken.
    task automatic run(input int cycles, input int nQuads);
        int left = nQuads;
        iREADY = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            if (!pending && left > 0) begin
                loadQuad(1'b0);
                left--;
            end
            step();
        end
    endtask

    // Stream until the head of the scoreboard matches the given queue depth and index.
    task automatic runUntil(input int depth, input int idx);
        int n = 0;
        iREADY = 1'b1;
        while (!(expQ.size() == depth && (idx < 0 || int'(expQ[0].idx) == idx)) && n < 40) begin
            if (!pending) loadQuad(1'b0);
            step();
            n++;
        end
        if (n >= 40) checkVal("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        iRESET = 1'b0; iCLR = 1'b0; iREADY = 1'b1; pending = 1'b0; expIdx = '0;
        for (int i = 0; i < 4; i++) begin quadRe[i] = '0; quadIm[i] = '0; end
        #2;
        checkVal("rst_oVALID", 32'(oVALID), 32'd0);
        checkVal("rst_oREADY", 32'(oREADY), 32'd0);
        checkVal("rst_oRE", 32'(oRE), 32'd0);
        checkVal("rst_oINDEX", 32'(oINDEX), 32'd0);
        step();
        step();
        iRESET = 1'b1;
        step();

        // Single quad (1,-1)..(4,-4)
        for (int i = 0; i < 4; i++) begin
            quadRe[i] = BIT'(i + 1);
            quadIm[i] = -BIT'(i + 1);
        end
        pending = 1'b1;
        iREADY = 1'b1;
        for (int c = 0; c < 7; c++) step();

        // Back-to-back frames, continuing then wrapping the index
        run(20, 4);

        // Backpressure: stall three cycles on lane 1
        runUntil(3, -1);
        iREADY = 1'b0;
        for (int c = 0; c < 3; c++) step();
        run(8, 1);

        // Clear at lane 2 of index 6
        runUntil(2, 6);
        iCLR = 1'b1;
        iREADY = 1'b0;
        step();
        iCLR = 1'b0;
        run(8, 1);

        // Async reset asserted between edges at lane 1
        runUntil(3, -1);
        #2;
        iRESET = 1'b0;
        #1;
        checkVal("arst_oVALID", 32'(oVALID), 32'd0);
        checkVal("arst_oRE", 32'(oRE), 32'd0);
        checkVal("arst_oIM", 32'(oIM), 32'd0);
        checkVal("arst_oINDEX", 32'(oINDEX), 32'd0);
        expQ.delete();
        expIdx = '0;
        pending = 1'b0;
        step();
        iRESET = 1'b1;
        run(8, 1);

        // Signed extremes
        loadQuad(1'b1);
        run(8, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
